// File: rtl/nibble_serial_sub.sv
// Nibble-serial two's-complement subtractor: A - B, one 4-bit slice per clock, LSB first.
// Optional macro NSUB_SAT_EN saturates diff on signed overflow.
module nibble_serial_sub #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);
  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 2) ? $clog2(NIBBLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           r_state, w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_a, r_b, r_acc;
  logic             r_carry;
  logic [WIDTH-1:0] r_diff;
  logic             r_borrow, r_ovf, r_zero, r_neg;

  logic [CW+1:0]    w_bit;
  logic [3:0]       w_ak, w_bk;
  logic [4:0]       w_sum;
  logic [WIDTH-1:0] w_raw, w_diff;
  logic             w_ovf, w_last;

  initial begin : width_chk
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  assign busy   = (r_state != IDLE);
  assign done   = (r_state == DONE);
  assign w_last = (r_cnt == LAST);

  // Slice adder: a_k + ~b_k + carry; carry seeded with 1 gives two's-complement subtract.
  assign w_bit = {r_cnt, 2'b00};
  assign w_ak  = r_a[w_bit +: 4];
  assign w_bk  = r_b[w_bit +: 4];
  assign w_sum = {1'b0, w_ak} + {1'b0, ~w_bk} + {4'b0000, r_carry};

  always_comb begin
    w_raw = r_acc;
    w_raw[w_bit +: 4] = w_sum[3:0];
  end

  assign w_ovf = (r_a[WIDTH-1] != r_b[WIDTH-1]) & (w_raw[WIDTH-1] != r_a[WIDTH-1]);

`ifdef NSUB_SAT_EN
  always_comb begin
    w_diff = w_raw;
    if (w_ovf)
      w_diff = r_a[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  end
`else
  assign w_diff = w_raw;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt    <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_acc    <= '0;
      r_carry  <= 1'b0;
      r_diff   <= '0;
      r_borrow <= 1'b0;
      r_ovf    <= 1'b0;
      r_zero   <= 1'b0;
      r_neg    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          r_a     <= a;
          r_b     <= b;
          r_acc   <= '0;
          r_carry <= 1'b1;
          r_cnt   <= '0;
        end
        RUN: begin
          r_acc   <= w_raw;
          r_carry <= w_sum[4];
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_diff   <= w_diff;
            r_borrow <= ~w_sum[4];
            r_ovf    <= w_ovf;
            r_zero   <= (w_diff == '0);
            r_neg    <= w_diff[WIDTH-1];
          end
        end
        default: ;
      endcase
    end
  end

  assign diff   = r_diff;
  assign borrow = r_borrow;
  assign ovf    = r_ovf;
  assign zero   = r_zero;
  assign neg    = r_neg;
endmodule

// File: tb/tb_nibble_serial_sub.sv
// Directed bench for nibble_serial_sub (WIDTH=16); expectations follow NSUB_SAT_EN when defined.
module tb_nibble_serial_sub;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [15:0] a, b, diff;
  logic        busy, done, borrow, ovf, zero, neg;
  int          errors = 0;
  int          checks = 0;
  int          lat;
  int          pulses;

  nibble_serial_sub #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow(borrow),
    .ovf(ovf), .zero(zero), .neg(neg)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_res(input string tag, input logic [15:0] d, input logic br,
                         input logic ov, input logic z, input logic n);
    chk({tag, ".diff"},   32'(diff),   32'(d));
    chk({tag, ".borrow"}, 32'(borrow), 32'(br));
    chk({tag, ".ovf"},    32'(ovf),    32'(ov));
    chk({tag, ".zero"},   32'(zero),   32'(z));
    chk({tag, ".neg"},    32'(neg),    32'(n));
  endtask

  // Pulse start for one cycle at a negedge; return negedges elapsed after the start edge until done.
  task automatic run_op(input string tag, input logic [15:0] va, input logic [15:0] vb);
    a = va; b = vb; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'hDEAD; b = 16'hBEEF;
    lat = 1;
    chk({tag, ".busy_e0"}, 32'(busy), 32'd1);
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".latency"}, 32'(lat), 32'd5);
    chk({tag, ".busy_done"}, 32'(busy), 32'd1);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk_res("rst", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);

    run_op("t1", 16'h1234, 16'h0234);
    chk_res("t1", 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("t1.done_once", 32'(done), 32'd0);
    chk("t1.idle", 32'(busy), 32'd0);

    run_op("t2", 16'h0000, 16'h0001);
    chk_res("t2", 16'hFFFF, 1'b1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);

    run_op("t3", 16'hA5A5, 16'hA5A5);
    chk_res("t3", 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);

    run_op("t4", 16'h8000, 16'h0001);
`ifdef NSUB_SAT_EN
    chk_res("t4", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1);
`else
    chk_res("t4", 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0);
`endif
    @(negedge clk);

    run_op("t5", 16'h7FFF, 16'hFFFF);
`ifdef NSUB_SAT_EN
    chk_res("t5", 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0);
`else
    chk_res("t5", 16'h8000, 1'b1, 1'b1, 1'b0, 1'b1);
`endif
    @(negedge clk);

    // start held high through RUN and DONE must be ignored
    a = 16'h0010; b = 16'h0001; start = 1'b1;
    @(negedge clk);
    a = 16'hFFFF; b = 16'h0000;
    lat = 1; pulses = 0;
    while (!done && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("t6.latency", 32'(lat), 32'd5);
    if (done) pulses++;
    chk_res("t6", 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    start = 1'b0;
    chk("t6.busy_after", 32'(busy), 32'd0);
    repeat (6) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("t6.pulses", 32'(pulses), 32'd1);
    chk("t6.still_idle", 32'(busy), 32'd0);
    chk("t6.diff_hold", 32'(diff), 32'h000F);

    // reset during the second RUN cycle
    a = 16'h00FF; b = 16'h0001; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("t7.busy", 32'(busy), 32'd0);
    chk("t7.done", 32'(done), 32'd0);
    chk_res("t7", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0);
    pulses = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) pulses++;
    end
    chk("t7.no_done", 32'(pulses), 32'd0);

    run_op("t8", 16'h5000, 16'h1234);
    chk_res("t8", 16'h3DCC, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/nibble_serial_sub.md
Name: nibble_serial_sub

Overview:
Multi-cycle two's-complement subtractor computing A − B one 4-bit nibble per clock, LSB nibble first.
Each nibble step forms a + ~b + carry, the subtract-direction counterpart of the datapath's 4-bit carry-lookahead add slice.
Used where area matters more than latency, e.g. a multi-cycle compare/subtract unit beside the single-cycle ALU.
Start/busy/done handshake; result and flags (borrow, overflow, zero, negative) are registered.

Parameters:
WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 8.
NIBBLES, WIDTH/4, derived local constant; not overridable.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous active-high reset.
start  input  1  request; sampled only in IDLE.
a  input  WIDTH  minuend; sampled with accepted start.
b  input  WIDTH  subtrahend; sampled with accepted start.
busy  output  1  high whenever state ≠ IDLE.
done  output  1  one-cycle pulse: result valid.
diff  output  WIDTH  result A − B (or saturated, see feature).
borrow  output  1  unsigned borrow = ~final carry (1 when A < B unsigned).
ovf  output  1  signed overflow.
zero  output  1  diff == 0.
neg  output  1  diff[WIDTH-1].

Behaviour:
- rst, synchronous, dominates everything.
  - State → IDLE; nibble counter, internal operand/accumulator registers and carry cleared.
  - diff, borrow, ovf, zero, neg, busy, done all 0.
  - Reset mid-operation discards the operation; no done pulse.
- States: IDLE, RUN, DONE.
- IDLE: on an edge with start=1:
  - latch a, b into internal registers;
  - carry ← 1, counter ← 0;
  - → RUN.
  - start=0: stay in IDLE.
- RUN: each edge processes nibble k = counter.
  - {c_out, s} = a_k + ~b_k + carry, 5-bit result.
  - s written into accumulator nibble k; carry ← c_out; counter +1.
  - On the edge processing k = NIBBLES−1:
    - → DONE;
    - diff ← accumulator with final nibble;
    - flags ← computed from that value.
- DONE: done=1 for exactly this one cycle, then → IDLE unconditionally.
- Latency: start sampled at edge E0; nibbles processed at E1..E_NIBBLES; done high in the cycle after E_NIBBLES.
  - WIDTH=16: done high 4 cycles after the start edge.
  - Back-to-back throughput: one operation per NIBBLES+2 cycles.
- start while busy (RUN or DONE): ignored; latched operands unaffected; no queuing.
- a/b changing after acceptance: no effect.
- diff and flags hold the last completed result until the next completion or rst; they do not change during RUN.
- Flag rules, evaluated on the final (pre-saturation) result:
  - borrow = ~c_out of the last nibble.
  - ovf = (a[MSB] ≠ b[MSB]) & (raw[MSB] ≠ a[MSB]).
  - zero and neg are computed from the diff value actually output.
- Arithmetic is modulo 2^WIDTH.
  - Borrow wrap-around is normal: 0 − 1 → all ones, borrow=1.

Optional Feature:
Macro NSUB_SAT_EN.
- Defined: when ovf=1, diff saturates.
  - a[MSB]=0 → 0x7FFF (max positive).
  - a[MSB]=1 → 0x8000 (min negative), generalised to WIDTH.
  - ovf still reports 1; borrow is unchanged (raw); zero/neg reflect the saturated value.
- Not defined: diff is always the wrapped raw result; no saturation logic is synthesised.

Test Plan:
- a=0x1234, b=0x0234, start one cycle → done exactly 4 cycles after start edge; diff=0x1000, borrow=0, ovf=0, zero=0, neg=0; busy high E0..done cycle.
- a=0x0000, b=0x0001 → diff=0xFFFF, borrow=1, neg=1, ovf=0; then a=b=0xA5A5 → diff=0x0000, zero=1, borrow=0.
- a=0x8000, b=0x0001 → ovf=1, borrow=0.
  - Without NSUB_SAT_EN: diff=0x7FFF, neg=0.
  - With NSUB_SAT_EN: diff=0x8000, neg=1.
- a=0x7FFF, b=0xFFFF → ovf=1, borrow=1.
  - Without NSUB_SAT_EN: diff=0x8000.
  - With NSUB_SAT_EN: diff=0x7FFF.
- Start op 0x0010−0x0001, re-pulse start with a=0xFFFF, b=0 during RUN and DONE → second request ignored; diff=0x000F; single done pulse; busy low afterwards.
- Start an op, assert rst at the second RUN cycle → next edge: all outputs 0, IDLE, no done pulse; a fresh start then completes normally with correct diff.
